// File: rtl/bfp_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bfp_pkg
// Description : Shared definitions for the BFP-to-FP32 normalizer: binary32
//               field widths, exponent bias and infinity code, the rounding
//               mode enumeration and the packed binary32 word layout.
// Revision    : 1.0 - initial release
// ============================================================================
package bfp_pkg;

    localparam int          c_FP32_EXPW  = 8;
    localparam int          c_FP32_FRACW = 23;
    localparam int          c_FP32_BIAS  = 127;
    localparam logic [7:0]  c_EXP_INF    = 8'hFF;

    typedef enum logic {
        RND_TRUNC = 1'b0,
        RND_RNE   = 1'b1
    } rnd_mode_e;

    typedef struct packed {
        logic                    sign;
        logic [c_FP32_EXPW-1:0]  exp;
        logic [c_FP32_FRACW-1:0] frac;
    } fp32_t;

endpackage
`default_nettype wire

// File: rtl/bfp_fp32_normalizer_if.sv
`default_nettype none
// ============================================================================
// Module      : bfp_fp32_normalizer_if
// Description : Input and output streams of the BFP-to-FP32 normalizer.
//               master = producer/consumer side, slave = the normalizer.
//   i_valid/o_ready           input beat handshake
//   i_sign/i_exp/i_man        BFP result (sign, biased exponent, magnitude)
//   i_rnd_mode                0 = truncate, 1 = round-to-nearest-even
//   o_valid/i_ready           output beat handshake
//   o_fp                      binary32 result
//   o_ovf/o_unf/o_inexact     exception flags
// Revision    : 1.0 - initial release
// ============================================================================
interface bfp_fp32_normalizer_if #(
    parameter int MANW = 10,
    parameter int EXPW = 9
) ();

    logic            i_valid;
    logic            o_ready;
    logic            i_sign;
    logic [EXPW-1:0] i_exp;
    logic [MANW-1:0] i_man;
    logic            i_rnd_mode;
    logic            o_valid;
    logic            i_ready;
    logic [31:0]     o_fp;
    logic            o_ovf;
    logic            o_unf;
    logic            o_inexact;

    modport master (
        output i_valid, i_sign, i_exp, i_man, i_rnd_mode, i_ready,
        input  o_ready, o_valid, o_fp, o_ovf, o_unf, o_inexact
    );

    modport slave (
        input  i_valid, i_sign, i_exp, i_man, i_rnd_mode, i_ready,
        output o_ready, o_valid, o_fp, o_ovf, o_unf, o_inexact
    );

endinterface
`default_nettype wire

// File: rtl/bfp_lzc.sv
`default_nettype none
// ============================================================================
// Module      : bfp_lzc
// Description : Parametrised leading-zero counter.
//   i_data  in  WIDTH          value to scan
//   o_cnt   out clog2(WIDTH)+1 number of leading zeros (WIDTH when all zero)
//   o_zero  out 1              i_data is all zeros
// Revision    : 1.0 - initial release
// ============================================================================
module bfp_lzc #(
    parameter  int WIDTH = 10,
    localparam int c_CW  = $clog2(WIDTH) + 1
) (
    input  logic [WIDTH-1:0] i_data,
    output logic [c_CW-1:0]  o_cnt,
    output logic             o_zero
);

    // Ascending scan: the highest set bit is the last one to write o_cnt.
    always_comb begin
        o_cnt = c_CW'(WIDTH);
        for (int i = 0; i < WIDTH; i++) begin
            if (i_data[i]) begin
                o_cnt = c_CW'(WIDTH - 1 - i);
            end
        end
    end

    assign o_zero = ~|i_data;

endmodule
`default_nettype wire

// File: rtl/bfp_fp32_normalizer.sv
`default_nettype none
// ============================================================================
// Module      : bfp_fp32_normalizer
// Description : Three-stage valid/ready pipeline converting a block-floating-
//               point result (sign, biased exponent, integer magnitude with
//               MULBFPMANSIZE fraction bits) into IEEE-754 binary32 with
//               truncate/RNE rounding, subnormals or flush-to-zero, and
//               overflow/underflow/inexact flags.
//   i_clk   in  1  clock
//   i_rst   in  1  synchronous active-high reset
//   bus     slave  stream interface (see bfp_fp32_normalizer_if)
// Revision    : 1.0 - initial release
// ============================================================================
module bfp_fp32_normalizer
    import bfp_pkg::*;
#(
    parameter int GRPSIZE       = 16,
    parameter int BFPEXPSIZE    = 8,
    parameter int BFPMANSIZE    = 4,
    parameter int MULBFPMANSIZE = (BFPMANSIZE - 1) * 2,
    parameter int LEVELS        = $clog2(GRPSIZE),
    parameter int FTZ           = 0
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    bfp_fp32_normalizer_if.slave    bus
);

    localparam int c_MANW  = MULBFPMANSIZE + LEVELS;
    localparam int c_EXPW  = BFPEXPSIZE + 1;
    localparam int c_CW    = $clog2(c_MANW) + 1;
    localparam int c_EW    = c_EXPW + 2;
    localparam int c_FRAC  = MULBFPMANSIZE;
    // Alignment frame: bit 127 is the hidden-one position, 126..104 the
    // fraction, 103 guard, the rest feeds sticky. Wide enough that a
    // 32-bit mantissa shifted by 25 loses nothing.
    localparam int c_FRAME = 128;
    localparam logic [c_EW-1:0] c_MAX_SH = c_EW'(25);

    // ------------------------------------------------------------------
    // Handshake: every stage advances together unless the output is stuck.
    // ------------------------------------------------------------------
    logic w_en;
    logic r3_valid;

    assign w_en        = !r3_valid || bus.i_ready;
    assign bus.o_ready = w_en;

    // ------------------------------------------------------------------
    // Stage 1: capture beat, leading-zero count and unbiased-to-FP exponent
    // ------------------------------------------------------------------
    logic [c_CW-1:0] w_lz;
    logic            w_zero;
    logic [c_EW-1:0] w_e1;

    bfp_lzc #(.WIDTH(c_MANW)) u_lzc (
        .i_data (bus.i_man),
        .o_cnt  (w_lz),
        .o_zero (w_zero)
    );

    // e = i_exp + (MANW-1-lz) - FRAC, widened so it never wraps.
    assign w_e1 = {{2{bus.i_exp[c_EXPW-1]}}, bus.i_exp}
                + c_EW'(c_MANW - 1) - c_EW'(w_lz) - c_EW'(c_FRAC);

    logic              r1_valid, r1_sign, r1_zero;
    rnd_mode_e         r1_rnd;
    logic [c_CW-1:0]   r1_lz;
    logic [c_MANW-1:0] r1_man;
    logic [c_EW-1:0]   r1_e;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r1_valid <= 1'b0;
            r1_sign  <= 1'b0;
            r1_zero  <= 1'b0;
            r1_rnd   <= RND_TRUNC;
            r1_lz    <= '0;
            r1_man   <= '0;
            r1_e     <= '0;
        end else if (w_en) begin
            r1_valid <= bus.i_valid;
            r1_sign  <= bus.i_sign;
            r1_zero  <= w_zero;
            r1_rnd   <= rnd_mode_e'(bus.i_rnd_mode);
            r1_lz    <= w_lz;
            r1_man   <= bus.i_man;
            r1_e     <= w_e1;
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: align into hidden/fraction/guard/sticky
    // ------------------------------------------------------------------
    logic [c_MANW-1:0]  w_norm;
    logic [c_FRAME-1:0] w_frame;
    logic [c_FRAME-1:0] w_aligned;
    logic               w_is_norm;
    logic [c_EW-1:0]    w_sub_amt;
    logic [4:0]         w_shamt;

    assign w_norm    = r1_man << r1_lz;
    assign w_frame   = {w_norm, {(c_FRAME - c_MANW){1'b0}}};
    assign w_is_norm = !r1_e[c_EW-1] && (r1_e != '0);
    // Subnormals sit 1-e places below the hidden position; beyond 25 the
    // whole mantissa is already below guard, so clamping keeps only sticky.
    assign w_sub_amt = c_EW'(1) - r1_e;
    assign w_shamt   = w_is_norm ? 5'd0
                     : ((w_sub_amt > c_MAX_SH) ? 5'd25 : w_sub_amt[4:0]);
    assign w_aligned = w_frame >> w_shamt;

    logic              r2_valid, r2_sign, r2_zero, r2_guard, r2_sticky;
    rnd_mode_e         r2_rnd;
    logic [22:0]       r2_frac;
    logic [c_EW-1:0]   r2_exp;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r2_valid  <= 1'b0;
            r2_sign   <= 1'b0;
            r2_zero   <= 1'b0;
            r2_guard  <= 1'b0;
            r2_sticky <= 1'b0;
            r2_rnd    <= RND_TRUNC;
            r2_frac   <= '0;
            r2_exp    <= '0;
        end else if (w_en) begin
            r2_valid  <= r1_valid;
            r2_sign   <= r1_sign;
            r2_zero   <= r1_zero;
            r2_guard  <= w_aligned[103];
            r2_sticky <= |w_aligned[102:0];
            r2_rnd    <= r1_rnd;
            r2_frac   <= w_aligned[126:104];
            // A hidden one still in place means the value stayed normal.
            r2_exp    <= w_aligned[127] ? r1_e : '0;
        end
    end

    // ------------------------------------------------------------------
    // Stage 3: round and pack. Adding the increment to {exp, frac} lets a
    // fraction carry ripple into the exponent, including subnormal -> 1.
    // ------------------------------------------------------------------
    logic               w_inc, w_lost;
    logic [c_EW+22:0]   w_sum;
    logic [c_EW-1:0]    w_exp_rnd;
    fp32_t              w_fp;
    logic               w_ovf, w_unf, w_inexact;

    assign w_inc     = (r2_rnd == RND_RNE) && r2_guard && (r2_sticky || r2_frac[0]);
    assign w_lost    = r2_guard || r2_sticky;
    assign w_sum     = {r2_exp, r2_frac} + (c_EW + 23)'(w_inc);
    assign w_exp_rnd = w_sum[c_EW+22:23];

    always_comb begin
        w_fp.sign = r2_sign;
        w_fp.exp  = w_exp_rnd[7:0];
        w_fp.frac = w_sum[22:0];
        w_ovf     = 1'b0;
        w_unf     = 1'b0;
        w_inexact = w_lost;
        if (r2_zero) begin
            w_fp.exp  = '0;
            w_fp.frac = '0;
            w_inexact = 1'b0;
        end else if (w_exp_rnd >= c_EW'(c_EXP_INF)) begin
            w_fp.exp  = c_EXP_INF;
            w_fp.frac = '0;
            w_ovf     = 1'b1;
            w_inexact = 1'b1;
        end else if (w_exp_rnd == '0) begin
            if (FTZ != 0) begin
                w_fp.frac = '0;
                w_unf     = 1'b1;
                w_inexact = 1'b1;
            end else begin
                w_unf     = w_lost;
            end
        end
    end

    fp32_t r3_fp;
    logic  r3_ovf, r3_unf, r3_inexact;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r3_valid   <= 1'b0;
            r3_fp      <= '0;
            r3_ovf     <= 1'b0;
            r3_unf     <= 1'b0;
            r3_inexact <= 1'b0;
        end else if (w_en) begin
            r3_valid   <= r2_valid;
            r3_fp      <= w_fp;
            r3_ovf     <= w_ovf;
            r3_unf     <= w_unf;
            r3_inexact <= w_inexact;
        end
    end

    assign bus.o_valid   = r3_valid;
    assign bus.o_fp      = r3_fp;
    assign bus.o_ovf     = r3_ovf;
    assign bus.o_unf     = r3_unf;
    assign bus.o_inexact = r3_inexact;

endmodule
`default_nettype wire
